// File: rtl/sound_mixer.sv
// sound_mixer
//   Mixes the four sound channel samples into left/right samples for the AC97
//   path. One mix per I_STROBE frame, time-multiplexed one channel per clock,
//   then a single volume scale per side.
//
//   Optional feature macro: SOUND_MIXER_VIN_EN
//     Adds the cartridge VIN input as a fifth accumulated source (routed by
//     NR50[7] left / NR50[3] right), moves SCALE one clock later and
//     saturates the scaled result to the SAMPLE_W range.
//
// Ports
//   I_CLK          system clock
//   I_RESET_L      asynchronous active-low reset
//   I_STROBE       one-cycle frame pulse, starts a mix
//   I_MASTER_EN    NR52[7]; 0 forces the mix result to 0
//   I_NR50         [6:4] left volume, [2:0] right volume
//   I_NR51         [7:4] ch4..ch1 to left, [3:0] ch4..ch1 to right
//   I_CH1..4_SAMPLE signed channel samples
//   I_VIN_SAMPLE   signed cartridge audio (SOUND_MIXER_VIN_EN only)
//   O_LEFT/O_RIGHT signed mixed samples, held between mixes
//   O_VALID        one-cycle pulse when O_LEFT/O_RIGHT update
//   O_DROP         one-cycle pulse when a strobe arrives during a mix
//
// FSM states
//   state | meaning
//   IDLE  | waiting for I_STROBE; snapshot inputs and clear accumulators
//   ACC   | add one source per clock to the left/right accumulators
//   SCALE | multiply by volume+1, shift by 5, register outputs, pulse O_VALID

module sound_mixer #(
  parameter int SAMPLE_W = 20
) (
  input  logic                I_CLK,
  input  logic                I_RESET_L,
  input  logic                I_STROBE,
  input  logic                I_MASTER_EN,
  input  logic [7:0]          I_NR50,
  input  logic [7:0]          I_NR51,
  input  logic [SAMPLE_W-1:0] I_CH1_SAMPLE,
  input  logic [SAMPLE_W-1:0] I_CH2_SAMPLE,
  input  logic [SAMPLE_W-1:0] I_CH3_SAMPLE,
  input  logic [SAMPLE_W-1:0] I_CH4_SAMPLE,
`ifdef SOUND_MIXER_VIN_EN
  input  logic [SAMPLE_W-1:0] I_VIN_SAMPLE,
`endif
  output logic [SAMPLE_W-1:0] O_LEFT,
  output logic [SAMPLE_W-1:0] O_RIGHT,
  output logic                O_VALID,
  output logic                O_DROP
);

  localparam int AW = SAMPLE_W + 3;
  localparam int PW = SAMPLE_W + 7;
`ifdef SOUND_MIXER_VIN_EN
  localparam int NCH = 5;
`else
  localparam int NCH = 4;
`endif
  localparam int IDX_W = (NCH > 4) ? 3 : 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE
  } state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic signed [AW-1:0]        acc_l;
  logic signed [AW-1:0]        acc_r;
  logic signed [SAMPLE_W-1:0]  snap_ch [NCH];
  logic [7:0]                  snap_nr50;
  logic [7:0]                  snap_nr51;
  logic                        snap_master;

  logic [NCH-1:0]              route_l;
  logic [NCH-1:0]              route_r;
  logic [3:0]                  volp1_l;
  logic [3:0]                  volp1_r;
  logic signed [PW-1:0]        prod_l;
  logic signed [PW-1:0]        prod_r;
  logic signed [PW-1:0]        shr_l;
  logic signed [PW-1:0]        shr_r;
  logic [SAMPLE_W-1:0]         res_l;
  logic [SAMPLE_W-1:0]         res_r;

`ifdef SOUND_MIXER_VIN_EN
  assign route_l = {snap_nr50[7], snap_nr51[7:4]};
  assign route_r = {snap_nr50[3], snap_nr51[3:0]};
`else
  assign route_l = snap_nr51[7:4];
  assign route_r = snap_nr51[3:0];
`endif

`ifdef SOUND_MIXER_VIN_EN
  localparam logic signed [PW-1:0] S_MAX = {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PW-1:0] S_MIN = {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
`else
  // Without VIN the scaled sum always fits SAMPLE_W, so the upper bits are
  // pure sign copies and NR50[7]/[3] have no meaning.
  logic unused_bits;
  assign unused_bits = ^{shr_l[PW-1:SAMPLE_W], shr_r[PW-1:SAMPLE_W],
                         snap_nr50[7], snap_nr50[3]};
`endif

  // Shared scaler per side; vol+1 is zero-extended so it stays positive.
  always_comb begin
    volp1_l = {1'b0, snap_nr50[6:4]} + 4'd1;
    volp1_r = {1'b0, snap_nr50[2:0]} + 4'd1;
    prod_l  = PW'(acc_l) * $signed(PW'(volp1_l));
    prod_r  = PW'(acc_r) * $signed(PW'(volp1_r));
    shr_l   = prod_l >>> 5;
    shr_r   = prod_r >>> 5;
`ifdef SOUND_MIXER_VIN_EN
    if (shr_l > S_MAX)      res_l = S_MAX[SAMPLE_W-1:0];
    else if (shr_l < S_MIN) res_l = S_MIN[SAMPLE_W-1:0];
    else                    res_l = shr_l[SAMPLE_W-1:0];
    if (shr_r > S_MAX)      res_r = S_MAX[SAMPLE_W-1:0];
    else if (shr_r < S_MIN) res_r = S_MIN[SAMPLE_W-1:0];
    else                    res_r = shr_r[SAMPLE_W-1:0];
`else
    res_l = shr_l[SAMPLE_W-1:0];
    res_r = shr_r[SAMPLE_W-1:0];
`endif
    if (!snap_master) begin
      res_l = '0;
      res_r = '0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state       <= IDLE;
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      for (int i = 0; i < NCH; i++) snap_ch[i] <= '0;
      snap_nr50   <= '0;
      snap_nr51   <= '0;
      snap_master <= 1'b0;
      O_LEFT      <= '0;
      O_RIGHT     <= '0;
      O_VALID     <= 1'b0;
      O_DROP      <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      O_DROP  <= 1'b0;
      case (state)
        IDLE: begin
          if (I_STROBE) begin
            snap_ch[0]  <= $signed(I_CH1_SAMPLE);
            snap_ch[1]  <= $signed(I_CH2_SAMPLE);
            snap_ch[2]  <= $signed(I_CH3_SAMPLE);
            snap_ch[3]  <= $signed(I_CH4_SAMPLE);
`ifdef SOUND_MIXER_VIN_EN
            snap_ch[4]  <= $signed(I_VIN_SAMPLE);
`endif
            snap_nr50   <= I_NR50;
            snap_nr51   <= I_NR51;
            snap_master <= I_MASTER_EN;
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
            state       <= ACC;
          end
        end
        ACC: begin
          if (route_l[idx]) acc_l <= acc_l + AW'(snap_ch[idx]);
          if (route_r[idx]) acc_r <= acc_r + AW'(snap_ch[idx]);
          if (idx == LAST_IDX) state <= SCALE;
          else                 idx   <= idx + IDX_W'(1);
        end
        SCALE: begin
          O_LEFT  <= res_l;
          O_RIGHT <= res_r;
          O_VALID <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A strobe outside IDLE (including the SCALE edge) is lost.
      if (I_STROBE && (state != IDLE)) O_DROP <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

  localparam int W = 20;
`ifdef SOUND_MIXER_VIN_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         strobe;
  logic         master;
  logic [7:0]   nr50, nr51;
  logic [W-1:0] ch1, ch2, ch3, ch4;
`ifdef SOUND_MIXER_VIN_EN
  logic [W-1:0] vin;
`endif
  logic [W-1:0] o_left, o_right;
  logic         o_valid, o_drop;

  sound_mixer #(.SAMPLE_W(W)) dut (
    .I_CLK        (clk),
    .I_RESET_L    (rst_n),
    .I_STROBE     (strobe),
    .I_MASTER_EN  (master),
    .I_NR50       (nr50),
    .I_NR51       (nr51),
    .I_CH1_SAMPLE (ch1),
    .I_CH2_SAMPLE (ch2),
    .I_CH3_SAMPLE (ch3),
    .I_CH4_SAMPLE (ch4),
`ifdef SOUND_MIXER_VIN_EN
    .I_VIN_SAMPLE (vin),
`endif
    .O_LEFT       (o_left),
    .O_RIGHT      (o_right),
    .O_VALID      (o_valid),
    .O_DROP       (o_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c1, c2, c3, c4;
    int n50, n51;
    bit m;
    int el, er;
  } vec_t;

  typedef struct {
    int el;
    int er;
    int e0;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  vec_t vt[9];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int drop_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(int a, int b, int c, int d, int n50_v, int n51_v,
                              bit m_v, int el_v, int er_v);
    vec_t v;
    v.c1 = a; v.c2 = b; v.c3 = c; v.c4 = d;
    v.n50 = n50_v; v.n51 = n51_v; v.m = m_v;
    v.el = el_v; v.er = er_v;
    return v;
  endfunction

  // Scoreboard side: every O_VALID must match the oldest pending mix.
  always @(negedge clk) begin
    if (o_drop) drop_cnt++;
    if (o_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got O_VALID=1 required 0");
      end else begin
        cur = sb.pop_front();
        chk("left", $signed(o_left), cur.el);
        chk("right", $signed(o_right), cur.er);
        chk("latency", cyc - cur.e0, LAT);
      end
    end
  end

  task automatic apply(input vec_t v);
    ch1 = v.c1[W-1:0];
    ch2 = v.c2[W-1:0];
    ch3 = v.c3[W-1:0];
    ch4 = v.c4[W-1:0];
    nr50 = v.n50[7:0];
    nr51 = v.n51[7:0];
    master = v.m;
`ifdef SOUND_MIXER_VIN_EN
    vin = '0;
`endif
  endtask

  // Raises strobe after the next posedge; the DUT samples it one edge later.
  task automatic do_strobe(input bit push, input int el_v, input int er_v);
    exp_t e;
    @(posedge clk);
    #1;
    strobe = 1'b1;
    if (push) begin
      e.el = el_v; e.er = er_v; e.e0 = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int d0, v0;
    vt[0] = mk(1000, 0, 0, 0, 'h77, 'h11, 1, 250, 250);
    vt[1] = mk(-1000, 0, 0, 0, 'h77, 'h10, 1, -250, 0);
    vt[2] = mk(1000, 0, 0, 0, 'h30, 'h11, 1, 125, 31);
    vt[3] = mk(524287, 524287, 524287, 524287, 'h77, 'hFF, 1, 524287, 524287);
    vt[4] = mk(-524288, -524288, -524288, -524288, 'h77, 'hFF, 1, -524288, -524288);
    vt[5] = mk(524287, 524287, 524287, 524287, 'h77, 'hFF, 0, 0, 0);
    vt[6] = mk(-1000, 0, 0, 0, 'h00, 'h11, 1, -32, -32);
    vt[7] = mk(5, 100, -300, 7, 'hDA, 'h5A, 1, -56, 10);
    vt[8] = mk(1000, 0, 0, 0, 'h77, 'h00, 1, 0, 0);

    rst_n = 1'b0;
    strobe = 1'b0;
    apply(vt[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left", int'(o_left), 0);
    chk("rst_right", int'(o_right), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_drop", int'(o_drop), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      apply(vt[i]);
      do_strobe(1, vt[i].el, vt[i].er);
      drain();
    end

    // Second strobe two clocks in, inputs changed after the snapshot.
    apply(vt[0]);
    d0 = drop_cnt; v0 = valid_cnt;
    do_strobe(1, 250, 250);
    ch1 = 20'hFEC78; nr51 = 8'hFF; nr50 = 8'h00; master = 1'b0;
    do_strobe(0, 0, 0);
    drain();
    repeat (8) @(negedge clk);
    chk("busy_drop_count", drop_cnt - d0, 1);
    chk("busy_valid_count", valid_cnt - v0, 1);

    // Strobe on the SCALE edge is dropped.
    apply(vt[1]);
    d0 = drop_cnt; v0 = valid_cnt;
    do_strobe(1, -250, 0);
    repeat (3) @(posedge clk);
    do_strobe(0, 0, 0);
    drain();
    repeat (8) @(negedge clk);
    chk("scale_drop_count", drop_cnt - d0, 1);
    chk("scale_valid_count", valid_cnt - v0, 1);

    // Strobe one edge after SCALE is accepted.
    apply(vt[2]);
    d0 = drop_cnt;
    do_strobe(1, 125, 31);
    repeat (4) @(posedge clk);
    apply(vt[0]);
    do_strobe(1, 250, 250);
    drain();
    chk("b2b_drop_count", drop_cnt - d0, 0);

    // Reset at E3 of a mix: outputs clear at once, mix abandoned.
    apply(vt[7]);
    do_strobe(1, -56, 10);
    drain();
    apply(vt[0]);
    v0 = valid_cnt;
    do_strobe(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_left", int'(o_left), 0);
    chk("midrst_right", int'(o_right), 0);
    chk("midrst_valid", int'(o_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_valid", valid_cnt - v0, 0);
    apply(vt[0]);
    do_strobe(1, 250, 250);
    drain();

`ifdef SOUND_MIXER_VIN_EN
    apply(vt[3]);
    vin = 20'h7FFFF;
    nr50 = 8'hFF;
    do_strobe(1, 524287, 524287);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
